// File: rtl/writeback_unit.sv
// Writeback stage: selects the retiring value, or waits for and aligns load data,
// and drives the register file write port. Errors are reported as one-cycle pulses.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | ready; non-load writes retire the cycle after accept
// S_WAIT_LOAD | load accepted; waiting for dmem response or timeout
module writeback_unit #(
  parameter int XLEN    = 32,
  parameter int XADDR   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic [1:0]       i_wb_sel,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc_plus4,
  input  logic [XLEN-1:0]  i_csr_rdata,
  input  logic [2:0]       i_load_funct3,
  input  logic [1:0]       i_byte_off,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_wr_en,
  output logic [XADDR-1:0] o_rd_addr,
  output logic [XLEN-1:0]  o_rd_data,
  output logic             o_err
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [7:0] CNT_TERM = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [XADDR-1:0] rd_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             wr_en_q;
  logic             err_q;
  logic [XADDR-1:0] rd_addr_q;
  logic [XLEN-1:0]  rd_data_q;

  logic [XLEN-1:0]  sel_data_d;
  logic [15:0]      lane_d;
  logic [XLEN-1:0]  load_data_d;
  logic             load_ok_d;

  assign o_ready   = (state_q == S_IDLE);
  assign o_wr_en   = wr_en_q;
  assign o_err     = err_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;

  always_comb begin
    sel_data_d = i_csr_rdata;
    case (i_wb_sel)
      SEL_ALU: sel_data_d = i_alu_result;
      SEL_PC4: sel_data_d = i_pc_plus4;
      default: sel_data_d = i_csr_rdata;
    endcase
  end

  // Only the low halfword of the shifted word is ever needed; LW uses the raw word.
  always_comb begin
    lane_d      = 16'(i_dmem_rdata >> {off_q, 3'b000});
    load_data_d = i_dmem_rdata;
    load_ok_d   = 1'b0;
    case (f3_q)
      F3_LB: begin
        load_data_d = {{(XLEN-8){lane_d[7]}}, lane_d[7:0]};
        load_ok_d   = 1'b1;
      end
      F3_LBU: begin
        load_data_d = {{(XLEN-8){1'b0}}, lane_d[7:0]};
        load_ok_d   = 1'b1;
      end
      F3_LH: begin
        load_data_d = {{(XLEN-16){lane_d[15]}}, lane_d};
        load_ok_d   = ~off_q[0];
      end
      F3_LHU: begin
        load_data_d = {{(XLEN-16){1'b0}}, lane_d};
        load_ok_d   = ~off_q[0];
      end
      F3_LW: begin
        load_data_d = i_dmem_rdata;
        load_ok_d   = (off_q == 2'b00);
      end
      default: begin
        load_data_d = i_dmem_rdata;
        load_ok_d   = 1'b0;
      end
    endcase
  end

  // Write-port address/data only move on a real write, so they hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            if (i_wb_sel == SEL_LOAD) begin
              rd_q    <= i_rd_addr;
              f3_q    <= i_load_funct3;
              off_q   <= i_byte_off;
              cnt_q   <= '0;
              state_q <= S_WAIT_LOAD;
            end else if (i_rd_addr != '0) begin
              wr_en_q   <= 1'b1;
              rd_addr_q <= i_rd_addr;
              rd_data_q <= sel_data_d;
            end
          end
        end
        S_WAIT_LOAD: begin
          if (i_dmem_rvalid) begin
            state_q <= S_IDLE;
            if (!load_ok_d) begin
              err_q <= 1'b1;
            end else if (rd_q != '0) begin
              wr_en_q   <= 1'b1;
              rd_addr_q <= rd_q;
              rd_data_q <= load_data_d;
            end
          end else if (cnt_q == CNT_TERM) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter XADDR, default 5, register address width.
REQ-003 Parameter TIMEOUT, default 16, max cycles waiting for load data; legal range 2..255.
REQ-004 Port i_clk  in  1  CPU clock; all state rises on posedge.
REQ-005 Port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port i_valid  in  1  memory stage presents a retiring instruction.
REQ-007 Port o_ready  out  1  unit accepts an instruction this cycle.
REQ-008 Port i_rd_addr  in  XADDR  destination register.
REQ-009 Port i_wb_sel  in  2  source: 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-010 Ports i_alu_result, i_pc_plus4, i_csr_rdata  in  XLEN  candidate writeback data.
REQ-011 Port i_load_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 Port i_byte_off  in  2  load address bits [1:0].
REQ-013 Port i_dmem_rvalid  in  1  data memory read response valid.
REQ-014 Port i_dmem_rdata  in  XLEN  data memory read word.
REQ-015 Ports o_wr_en  out  1, o_rd_addr  out  XADDR, o_rd_data  out  XLEN  register file write port, all registered.
REQ-016 Port o_err  out  1  one-cycle pulse: load misaligned, illegal funct3, or timeout.

Function
REQ-017 Two states SHALL exist: IDLE, WAIT_LOAD; o_ready SHALL equal (state == IDLE).
REQ-018 Accept = i_valid && o_ready; inputs other than dmem signals SHALL be sampled only on accept.
REQ-019 Accept with i_wb_sel != 01 SHALL, on the next cycle, drive o_rd_addr = rd, o_rd_data = selected source, o_wr_en = (rd != 0); state stays IDLE (one instruction per cycle throughput).
REQ-020 Accept with i_wb_sel == 01 SHALL latch rd, funct3, byte_off, clear wait counter, enter WAIT_LOAD.
REQ-021 In WAIT_LOAD with i_dmem_rvalid, next cycle SHALL present aligned load data per REQ-022 with o_wr_en = (rd != 0), and state SHALL return to IDLE.
REQ-022 Alignment: byte lane = rdata >> (8*byte_off); LB/LBU take bits [7:0] sign/zero-extended; LH/LHU take bits [15:0] sign/zero-extended; LW whole word.
REQ-023 Misaligned (LH/LHU with byte_off[0]=1, LW with byte_off != 0) or illegal funct3 SHALL, on rvalid, pulse o_err one cycle, keep o_wr_en 0, return to IDLE.
REQ-024 Wait counter SHALL increment each WAIT_LOAD cycle without rvalid; reaching TIMEOUT-1 SHALL pulse o_err next cycle, no write, return to IDLE.
REQ-025 rvalid on the counter's terminal cycle SHALL win over timeout (normal write, no o_err).
REQ-026 i_dmem_rvalid in IDLE SHALL be ignored.
REQ-027 o_wr_en and o_err SHALL be single-cycle pulses and never both high in one cycle.
REQ-028 o_rd_addr/o_rd_data SHALL hold last values when o_wr_en is 0.

Reset
REQ-029 i_rst_n low SHALL asynchronously force state IDLE, counter 0, o_wr_en 0, o_err 0, o_rd_addr 0, o_rd_data 0.
REQ-030 Reset asserted in WAIT_LOAD SHALL abandon the load with no write and no o_err.
REQ-031 First accept SHALL be possible the first posedge after i_rst_n deasserts.

Verification
REQ-032 ALU back-to-back: rd=5 alu=0x12345678, then rd=6 pc+4=0x00000104 on consecutive cycles -> two consecutive o_wr_en pulses with those values, o_ready constant 1.
REQ-033 LB sign: off=3, rdata=0x80FFFFFF after 2-cycle wait -> o_rd_data=0xFFFFFF80, o_ready low 2 cycles then high; LBU same -> 0x00000080.
REQ-034 LHU off=2, rdata=0xBEEF1234 -> 0x0000BEEF; LH off=1 -> o_err pulse, no o_wr_en.
REQ-035 Timeout: load accepted, no rvalid for TIMEOUT cycles -> single o_err pulse, o_wr_en 0, o_ready returns 1; rvalid on terminal cycle instead -> normal write, no o_err.
REQ-036 rd=0 CSR writeback data 0xDEADBEEF -> o_wr_en stays 0; reset asserted mid WAIT_LOAD -> all outputs 0 immediately, subsequent rvalid ignored.
